// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide engine.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e o);
    return (o == OP_MULT) || (o == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Applies sign correction to the unsigned product or quotient/remainder pair.
module muldiv_sign_fix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw_i,
  input  logic               sign_a_i,
  input  logic               sign_b_i,
  input  logic               is_div_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [2*WIDTH-1:0] prod;

  // Quotient follows sign_a^sign_b, remainder follows the dividend.
  always_comb begin
    prod = (sign_a_i ^ sign_b_i) ? -raw_i : raw_i;
    if (is_div_i) begin
      lo_o = (sign_a_i ^ sign_b_i) ? -raw_i[WIDTH-1:0] : raw_i[WIDTH-1:0];
      hi_o = sign_a_i ? -raw_i[2*WIDTH-1:WIDTH] : raw_i[2*WIDTH-1:WIDTH];
    end else begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Shared iterative multiply/divide engine: one bit per cycle on magnitudes,
// sign correction in a final FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d, op_in;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, mul_next, div_next;
  logic [WIDTH-1:0]   opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   fix_hi, fix_lo, mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, prem, trial;
  logic               dz_q, dz_d, accept, div0, neg_a, neg_b;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  assign op_in  = op_e'(op);
  assign accept = (state_q == S_IDLE) && start && !flush;
  assign div0   = op_is_div(op_in) && (b == '0);
  assign neg_a  = op_is_signed(op_in) && a[WIDTH-1];
  assign neg_b  = op_is_signed(op_in) && b[WIDTH-1];
  assign mag_a  = mag(a, neg_a);
  assign mag_b  = mag(b, neg_b);

  // Shift-add step: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Restoring step: acc = {partial remainder, dividend bits / quotient bits}.
  assign prem     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign trial    = prem - {1'b0, opnd_q};
  assign div_next = trial[WIDTH] ? {prem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  muldiv_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .raw_i    (acc_q),
    .sign_a_i (sa_q),
    .sign_b_i (sb_q),
    .is_div_i (op_is_div(op_q)),
    .hi_o     (fix_hi),
    .lo_o     (fix_lo)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = div0 ? S_DONE : S_RUN;
      S_RUN: begin
        if (flush)                        state_d = S_IDLE;
        else if (cnt_q == CNT_W'(1))      state_d = S_FIX;
      end
      S_FIX:  state_d = flush ? S_IDLE : S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    op_d   = op_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    dz_d   = dz_q;
    if (accept) begin
      op_d  = op_in;
      sa_d  = neg_a;
      sb_d  = neg_b;
      cnt_d = CNT_W'(WIDTH);
      dz_d  = 1'b0;
      if (op_is_div(op_in)) begin
        acc_d  = {{WIDTH{1'b0}}, mag_a};
        opnd_d = mag_b;
      end else begin
        acc_d  = {{WIDTH{1'b0}}, mag_b};
        opnd_d = mag_a;
      end
      if (div0) begin
        hi_d = a;
        lo_d = '1;
        dz_d = 1'b1;
      end
    end else if (state_q == S_RUN && !flush) begin
      cnt_d = cnt_q - CNT_W'(1);
      acc_d = op_is_div(op_q) ? div_next : mul_next;
    end else if (state_q == S_FIX && !flush) begin
      hi_d = fix_hi;
      lo_d = fix_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q   <= OP_MULT;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else begin
      op_q   <= op_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      dz_q   <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit for the multicycle CPU datapath. It replaces the separate mult and div instances with one shared engine. The engine supports signed and unsigned MULT/DIV, a start/busy/done handshake, a divide-by-zero flag and a synchronous flush for exception entry. The hi/lo results feed the Hi/Lo registers through the existing select muxes.

Parameters:
WIDTH, 32, operand width in bits; hi/lo are each WIDTH bits; minimum 4.
CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
start  input  1  request; sampled only in IDLE.
op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU; sampled with start.
a  input  WIDTH  multiplicand / dividend; sampled with start.
b  input  WIDTH  multiplier / divisor; sampled with start.
flush  input  1  cancel the operation in flight; no done is produced.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; hi/lo are valid in that cycle.
hi  output  WIDTH  MULT: upper product; DIV: remainder.
lo  output  WIDTH  MULT: lower product; DIV: quotient.
div_zero  output  1  set with done when a DIV had b==0; cleared at the next accepted start.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0; counter and working registers are cleared. A reset during RUN/FIX aborts the operation.
- States: IDLE, RUN, FIX, DONE.
- IDLE with start=1:
  - Latch op and the magnitudes of a and b. For signed ops, record sign_a and sign_b; for unsigned ops, treat both signs as 0.
  - Load counter=WIDTH and clear div_zero.
  - Go to RUN, except for DIV/DIVU with b==0: go directly to DONE with hi=a, lo={WIDTH{1}}, div_zero=1.
- RUN: one bit per cycle; the counter decrements each cycle; at counter==1 the next state is FIX.
  - MULT: shift-add over a 2*WIDTH accumulator.
  - DIV: restoring division (shift the partial remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative).
- FIX: apply sign correction, then register hi/lo and go to DONE.
  - MULT: negate the 2*WIDTH product if sign_a^sign_b.
  - DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Quotient truncates toward zero. The remainder takes the sign of the dividend.
  - DIV signed MIN/-1 yields lo=MIN, hi=0; this is not an error.
- DONE: done=1 for exactly this cycle; next state IDLE. busy is low again in the following cycle.
- Latency: if start is sampled at edge k, done is high in the cycle after edge k+WIDTH+1, i.e. WIDTH+2 cycles after the start cycle. Divide-by-zero gives done one cycle after start.
- hi/lo hold their last values until the next FIX, or until a divide-by-zero DONE.
- start while busy=1: ignored. It is not queued.
- start and DONE in the same cycle: ignored. The CPU must re-assert start in IDLE.
- flush=1 in RUN/FIX: next state IDLE; hi/lo/div_zero unchanged; no done.
- flush in DONE: done still pulses.
- flush in IDLE: no effect, and flush has priority over start.
- reset has priority over flush and start.
- All arithmetic is modulo 2^WIDTH per half; no overflow flag is produced.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encodings: S_IDLE, S_RUN, S_FIX, S_DONE.
- Natural sub-module: muldiv_sign_fix, a combinational block parametrised by WIDTH.
  - Inputs: raw product or quotient/remainder, sign_a, sign_b, is_div.
  - Outputs: corrected hi/lo.
- The FSM, counter and iteration datapath stay in muldiv_unit.

Test Plan:
1. WIDTH=32, MULT a=-3 (0xFFFFFFFD), b=7 -> done after 34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
2. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high for 34 cycles, then low.
3. DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=100, b=7 -> lo=14, hi=2.
4. DIV a=0x1234, b=0 -> done one cycle after start; div_zero=1, hi=0x1234, lo=0xFFFFFFFF. A following MULT 2*3 clears div_zero and gives lo=6.
5. Start a MULT, assert flush at RUN cycle 10 -> busy drops the next cycle; no done; hi/lo keep the previous result. Pulse reset low mid-RUN -> all outputs 0 next cycle.
6. WIDTH=8: DIV a=0x80, b=0xFF (signed) -> lo=0x80, hi=0x00, done after 10 cycles. A start pulse while busy -> ignored, single done.
